multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle sequencer for the 4-bit-opcode CPU datapath: one ALU, one unified memory port and the register file are time-shared across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. It replaces per-instruction single-cycle decode with a Moore FSM plus a req/ack memory handshake. It also counts retired instructions and flags illegal opcodes. It sits between the instruction register (Opcode source) and the datapath mux/enable controls.

## Interface
- CNT_W, 16, width of retired-instruction counter
- Clk  in  1  clock, rising edge
- Rst_n  in  1  synchronous reset, active-low
- Run  in  1  permit start of a new instruction fetch
- Opcode  in  4  IR[15:12] from datapath; valid from DECODE onward
- Mem_ack  in  1  memory completes current access this cycle
- Mem_req  out  1  memory access request
- Memread / Memwrite  out  1 / 1  access direction, valid with Mem_req
- IorD  out  1  0 = PC address, 1 = ALUOut address
- IRwrite, PCwrite  out  1  IR load, unconditional PC load
- Branch  out  1  conditional PC load (datapath ANDs with Zero)
- PCsource  out  1  0 = ALU result, 1 = ALUOut (branch target)
- ALUsrcA  out  1  0 = PC, 1 = reg A
- ALUsrcB  out  2  00 = reg B, 01 = const 1, 10 = sign-ext imm, 11 = sign-ext offset
- ALUop  out  3  2 = add, 1 = subtract/compare, 4 = use funct
- Regwrite, Regdst, Memtoreg  out  1  register-file write controls
- Illegal  out  1  one-cycle pulse on undefined opcode
- Instr_count  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, WB_R, BRANCH, ADDR, MEM_RD, MEM_WR, WB_MEM. All outputs not listed for a state are 0.
- IDLE: go to FETCH when Run=1.
- FETCH: Mem_req=1, Memread=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=2.
  - Stay until Mem_ack=1.
  - In the ack cycle only, IRwrite=1 and PCwrite=1 (Mealy); then go to DECODE.
- DECODE: ALUsrcA=0, ALUsrcB=11, ALUop=2 (branch target into ALUOut). Latch Opcode into op_q.
  - Opcode 0 → EXEC_R; 1 → BRANCH; 3 or 11 → ADDR.
  - Any other opcode → Illegal=1 this cycle, instruction retires, next state FETCH if Run=1 else IDLE.
- EXEC_R: ALUsrcA=1, ALUsrcB=00, ALUop=4 → WB_R.
- WB_R: Regwrite=1, Regdst=1, Memtoreg=0 → retire.
- BRANCH: ALUsrcA=1, ALUsrcB=00, ALUop=1, Branch=1, PCsource=1 → retire.
- ADDR: ALUsrcA=1, ALUsrcB=10, ALUop=2. op_q=3 → MEM_RD; op_q=11 → MEM_WR.
- MEM_RD: Mem_req=1, Memread=1, IorD=1. Hold until Mem_ack, then → WB_MEM.
- WB_MEM: Regwrite=1, Regdst=0, Memtoreg=1 → retire.
- MEM_WR: Mem_req=1, Memwrite=1, IorD=1. Hold until Mem_ack, then retire.
- Retire:
  - Instr_count += 1, modulo 2^CNT_W; all-ones wraps to 0.
  - Next state is FETCH if Run=1, else IDLE.
  - Run is sampled only at retire and in IDLE. Dropping Run mid-instruction does not abort it.

## Timing
- Reset: state=IDLE, op_q=0, Instr_count=0. Every output is 0 in the reset cycle and in IDLE.
- Rst_n low in any state, including while Mem_req=1:
  - Next edge is IDLE and Mem_req=0.
  - The pending access is abandoned; memory must accept request withdrawal.
- Handshake:
  - Mem_req, Memread/Memwrite and IorD stay constant until the edge at which Mem_ack=1 is sampled.
  - Exactly one access completes per ack.
  - Mem_ack is ignored when Mem_req=0.
- Latency with zero-wait memory (ack in the request cycle), FETCH to next FETCH:
  - R-type 4 cycles, branch 3, load 5, store 4, illegal 2.
  - Each wait cycle adds 1.
- Illegal and the Instr_count update take effect at the same edge as the retiring transition.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - opcode constants OP_RTYPE=0, OP_BEQ=1, OP_LW=3, OP_SW=11
  - ALUop codes ALU_SUB=1, ALU_ADD=2, ALU_FUNCT=4
  - ALUsrcB encodings
  - state enum
- Sub-module mc_output_decode: combinational state (plus Mem_ack for IRwrite/PCwrite) to control word. The FSM register, op_q and counter stay in the top.

## Test plan
- Reset with Rst_n=0 for 2 cycles, Run=0 → all outputs 0, Instr_count=0, state stays IDLE.
- Run=1, Opcode=0, Mem_ack tied 1 → FETCH, DECODE, EXEC_R (ALUop=4), WB_R (Regwrite=1, Regdst=1); Instr_count=1 after 4 cycles.
- Opcode=3 with Mem_ack delayed 2 cycles in both FETCH and MEM_RD → Mem_req and Memread held constant; IorD 0 then 1; WB_MEM has Memtoreg=1; load takes 9 cycles total.
- Opcode=11 then Opcode=1, zero-wait → MEM_WR has Memwrite=1 and Regwrite=0; BRANCH has Branch=1, ALUop=1, PCsource=1; count increases by 2 over 7 cycles.
- Opcode=5 → Illegal pulses for 1 cycle in DECODE, back to FETCH; count increments. Preload Instr_count=16'hFFFF then retire one instruction → count 0.
- Rst_n=0 asserted in MEM_RD with Mem_req=1 → IDLE next edge, Mem_req=0, count 0; a later Mem_ack is ignored.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: opcodes, ALU and
// operand-select encodings, the sequencer state enum and the control word.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd3;
  localparam logic [3:0] OP_SW    = 4'd11;

  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_ADD   = 3'd2;
  localparam logic [2:0] ALU_FUNCT = 3'd4;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_OFFSET = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_WB_R   = 4'd4,
    ST_BRANCH = 4'd5,
    ST_ADDR   = 4'd6,
    ST_MEM_RD = 4'd7,
    ST_MEM_WR = 4'd8,
    ST_WB_MEM = 4'd9
  } state_t;

  // Full datapath control word; field order is also the debug/compare order.
  typedef struct packed {
    logic       mem_req;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
  } ctrl_t;

  // True for the four opcodes the sequencer knows how to execute.
  function automatic logic is_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode from the sequencer state. Only
// IRwrite/PCwrite (Mem_ack in FETCH) and Illegal (Opcode in DECODE) look at
// inputs; everything else is a pure function of the state register.
module mc_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ack,
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  // Per-state control word, zero for every field a state does not drive.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_ONE;
        ctrl.aluop   = ALU_ADD;
        ctrl.irwrite = mem_ack;
        ctrl.pcwrite = mem_ack;
      end
      ST_DECODE: begin
        ctrl.alusrcb = SRCB_OFFSET;
        ctrl.aluop   = ALU_ADD;
        ctrl.illegal = ~is_legal(opcode);
      end
      ST_EXEC_R: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALU_FUNCT;
      end
      ST_WB_R: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alusrca  = 1'b1;
        ctrl.alusrcb  = SRCB_REG;
        ctrl.aluop    = ALU_SUB;
        ctrl.branch   = 1'b1;
        ctrl.pcsource = 1'b1;
      end
      ST_ADDR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_WB_MEM: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: Moore FSM over FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// with a req/ack memory handshake, a retired-instruction counter and an
// illegal-opcode pulse.
//
// Handshake: Mem_req with Memread/Memwrite/IorD is held constant from the
// first request cycle until the rising edge at which Mem_ack=1 is sampled;
// that edge completes exactly one access. Mem_ack is ignored whenever
// Mem_req=0, and a synchronous reset withdraws a pending request.
//
// Count_load/Count_init give a synchronous counter preload (used to reach the
// wrap point without retiring 2^CNT_W instructions); load wins over retire.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Run,
  input  logic [3:0]       Opcode,
  input  logic             Mem_ack,
  input  logic             Count_load,
  input  logic [CNT_W-1:0] Count_init,
  output logic             Mem_req,
  output logic             Memread,
  output logic             Memwrite,
  output logic             IorD,
  output logic             IRwrite,
  output logic             PCwrite,
  output logic             Branch,
  output logic             PCsource,
  output logic             ALUsrcA,
  output logic [1:0]       ALUsrcB,
  output logic [2:0]       ALUop,
  output logic             Regwrite,
  output logic             Regdst,
  output logic             Memtoreg,
  output logic             Illegal,
  output logic [CNT_W-1:0] Instr_count,
  output logic [3:0]       State
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] count;
  ctrl_t            ctrl;
  logic             retire;

  mc_output_decode u_decode (
    .state   (state),
    .mem_ack (Mem_ack),
    .opcode  (Opcode),
    .ctrl    (ctrl)
  );

  // An instruction retires on the last cycle of its sequence.
  always_comb begin
    retire = 1'b0;
    case (state)
      ST_WB_R, ST_BRANCH, ST_WB_MEM: retire = 1'b1;
      ST_MEM_WR:                     retire = Mem_ack;
      ST_DECODE:                     retire = ctrl.illegal;
      default:                       retire = 1'b0;
    endcase
  end

  // Sequencer state, latched opcode and retired-instruction counter.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
      op_q  <= 4'd0;
      count <= '0;
    end else begin
      if (Count_load) begin
        count <= Count_init;
      end else if (retire) begin
        count <= count + CNT_ONE;
      end

      case (state)
        ST_IDLE: begin
          if (Run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (Mem_ack) state <= ST_DECODE;
        end
        ST_DECODE: begin
          op_q <= Opcode;
          case (Opcode)
            OP_RTYPE:     state <= ST_EXEC_R;
            OP_BEQ:       state <= ST_BRANCH;
            OP_LW, OP_SW: state <= ST_ADDR;
            default:      state <= Run ? ST_FETCH : ST_IDLE;
          endcase
        end
        ST_EXEC_R: state <= ST_WB_R;
        ST_ADDR:   state <= (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD: begin
          if (Mem_ack) state <= ST_WB_MEM;
        end
        ST_MEM_WR: begin
          if (Mem_ack) state <= Run ? ST_FETCH : ST_IDLE;
        end
        ST_WB_R, ST_BRANCH, ST_WB_MEM: state <= Run ? ST_FETCH : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Mem_req     = ctrl.mem_req;
  assign Memread     = ctrl.memread;
  assign Memwrite    = ctrl.memwrite;
  assign IorD        = ctrl.iord;
  assign IRwrite     = ctrl.irwrite;
  assign PCwrite     = ctrl.pcwrite;
  assign Branch      = ctrl.branch;
  assign PCsource    = ctrl.pcsource;
  assign ALUsrcA     = ctrl.alusrca;
  assign ALUsrcB     = ctrl.alusrcb;
  assign ALUop       = ctrl.aluop;
  assign Regwrite    = ctrl.regwrite;
  assign Regdst      = ctrl.regdst;
  assign Memtoreg    = ctrl.memtoreg;
  assign Illegal     = ctrl.illegal;
  assign Instr_count = count;
  assign State       = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each driven cycle pushes the
// hand-computed state/control/count vector for that cycle; a monitor on the
// falling edge pops and compares.
module tb_multicycle_controller;

  localparam int W = 38;

  // Hand-written state codes.
  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_EXEC_R = 4'd3, S_WB_R = 4'd4, S_BRANCH = 4'd5,
                         S_ADDR = 4'd6, S_MEM_RD = 4'd7, S_MEM_WR = 4'd8,
                         S_WB_MEM = 4'd9;

  // Control words: req rd wr iord irw pcw br pcs asa | asb | aop | rw rdst mtr ill
  localparam logic [17:0] C_ZERO   = 18'b000000000_00_000_0000;
  localparam logic [17:0] C_FWAIT  = 18'b110000000_01_010_0000;
  localparam logic [17:0] C_FACK   = 18'b110011000_01_010_0000;
  localparam logic [17:0] C_DEC    = 18'b000000000_11_010_0000;
  localparam logic [17:0] C_DECILL = 18'b000000000_11_010_0001;
  localparam logic [17:0] C_EXEC   = 18'b000000001_00_100_0000;
  localparam logic [17:0] C_WBR    = 18'b000000000_00_000_1100;
  localparam logic [17:0] C_BR     = 18'b000000111_00_001_0000;
  localparam logic [17:0] C_ADDR   = 18'b000000001_10_010_0000;
  localparam logic [17:0] C_MRD    = 18'b110100000_00_000_0000;
  localparam logic [17:0] C_MWR    = 18'b101100000_00_000_0000;
  localparam logic [17:0] C_WBM    = 18'b000000000_00_000_1010;

  logic        Clk = 1'b0;
  logic        Rst_n, Run, Mem_ack, Count_load;
  logic [3:0]  Opcode;
  logic [15:0] Count_init;
  logic        Mem_req, Memread, Memwrite, IorD, IRwrite, PCwrite, Branch;
  logic        PCsource, ALUsrcA, Regwrite, Regdst, Memtoreg, Illegal;
  logic [1:0]  ALUsrcB;
  logic [2:0]  ALUop;
  logic [15:0] Instr_count;
  logic [3:0]  State;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  multicycle_controller #(.CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Opcode(Opcode), .Mem_ack(Mem_ack),
    .Count_load(Count_load), .Count_init(Count_init),
    .Mem_req(Mem_req), .Memread(Memread), .Memwrite(Memwrite), .IorD(IorD),
    .IRwrite(IRwrite), .PCwrite(PCwrite), .Branch(Branch), .PCsource(PCsource),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUop(ALUop), .Regwrite(Regwrite),
    .Regdst(Regdst), .Memtoreg(Memtoreg), .Illegal(Illegal),
    .Instr_count(Instr_count), .State(State)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Drive one cycle's inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic cyc(input logic rst, input logic run, input logic ack,
                     input logic [3:0] opc, input logic ld,
                     input logic [3:0] est, input logic [17:0] ectl,
                     input logic [15:0] ecnt, input string nm);
    @(posedge Clk);
    #1;
    Rst_n      = rst;
    Run        = run;
    Mem_ack    = ack;
    Opcode     = opc;
    Count_load = ld;
    exp_q.push_back({est, ectl, ecnt});
    name_q.push_back(nm);
  endtask

  // Monitor: compare the full observable vector mid-cycle.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] got, exp;
      string nm;
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {State, Mem_req, Memread, Memwrite, IorD, IRwrite, PCwrite, Branch,
             PCsource, ALUsrcA, ALUsrcB, ALUop, Regwrite, Regdst, Memtoreg,
             Illegal, Instr_count};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
    end
  end

  initial begin
    Rst_n = 1'b0; Run = 1'b0; Mem_ack = 1'b0; Opcode = 4'd0;
    Count_load = 1'b0; Count_init = 16'hFFFF;

    // Reset, Run=0
    cyc(0, 0, 0, 4'd0, 0, S_IDLE, C_ZERO, 16'd0, "reset_1");
    cyc(0, 0, 0, 4'd0, 0, S_IDLE, C_ZERO, 16'd0, "reset_2");
    cyc(1, 0, 1, 4'd0, 0, S_IDLE, C_ZERO, 16'd0, "idle_no_run");

    // R-type, zero-wait: 4 cycles
    cyc(1, 1, 1, 4'd0, 0, S_IDLE,   C_ZERO, 16'd0, "idle_run");
    cyc(1, 1, 1, 4'd0, 0, S_FETCH,  C_FACK, 16'd0, "r_fetch");
    cyc(1, 1, 1, 4'd0, 0, S_DECODE, C_DEC,  16'd0, "r_decode");
    cyc(1, 1, 1, 4'd0, 0, S_EXEC_R, C_EXEC, 16'd0, "r_exec");
    cyc(1, 1, 1, 4'd0, 0, S_WB_R,   C_WBR,  16'd0, "r_wb");

    // Load with 2 wait cycles in FETCH and MEM_RD: 9 cycles
    cyc(1, 1, 0, 4'd3,  0, S_FETCH,  C_FWAIT, 16'd1, "ld_fetch_w1");
    cyc(1, 1, 0, 4'd3,  0, S_FETCH,  C_FWAIT, 16'd1, "ld_fetch_w2");
    cyc(1, 1, 1, 4'd3,  0, S_FETCH,  C_FACK,  16'd1, "ld_fetch_ack");
    cyc(1, 1, 1, 4'd3,  0, S_DECODE, C_DEC,   16'd1, "ld_decode");
    cyc(1, 1, 1, 4'd11, 0, S_ADDR,   C_ADDR,  16'd1, "ld_addr");
    cyc(1, 1, 0, 4'd11, 0, S_MEM_RD, C_MRD,   16'd1, "ld_mem_w1");
    cyc(1, 1, 0, 4'd11, 0, S_MEM_RD, C_MRD,   16'd1, "ld_mem_w2");
    cyc(1, 1, 1, 4'd11, 0, S_MEM_RD, C_MRD,   16'd1, "ld_mem_ack");
    cyc(1, 1, 1, 4'd11, 0, S_WB_MEM, C_WBM,   16'd1, "ld_wb");

    // Store then branch, zero-wait: 7 cycles, count 2 -> 4
    cyc(1, 1, 1, 4'd11, 0, S_FETCH,  C_FACK, 16'd2, "sw_fetch");
    cyc(1, 1, 1, 4'd11, 0, S_DECODE, C_DEC,  16'd2, "sw_decode");
    cyc(1, 1, 1, 4'd11, 0, S_ADDR,   C_ADDR, 16'd2, "sw_addr");
    cyc(1, 1, 1, 4'd11, 0, S_MEM_WR, C_MWR,  16'd2, "sw_mem");
    cyc(1, 1, 1, 4'd1,  0, S_FETCH,  C_FACK, 16'd3, "beq_fetch");
    cyc(1, 1, 1, 4'd1,  0, S_DECODE, C_DEC,  16'd3, "beq_decode");
    cyc(1, 1, 1, 4'd1,  0, S_BRANCH, C_BR,   16'd3, "beq_branch");

    // Illegal opcodes: one to FETCH, one with Run=0 to IDLE
    cyc(1, 1, 1, 4'd5, 0, S_FETCH,  C_FACK,   16'd4, "ill5_fetch");
    cyc(1, 1, 1, 4'd5, 0, S_DECODE, C_DECILL, 16'd4, "ill5_decode");
    cyc(1, 1, 1, 4'd7, 0, S_FETCH,  C_FACK,   16'd5, "ill7_fetch");
    cyc(1, 0, 1, 4'd7, 0, S_DECODE, C_DECILL, 16'd5, "ill7_decode");
    cyc(1, 0, 1, 4'd7, 0, S_IDLE,   C_ZERO,   16'd6, "ill7_idle");

    // Counter wrap from all-ones
    cyc(1, 0, 0, 4'd0,  1, S_IDLE,   C_ZERO,   16'd6,    "preload");
    cyc(1, 1, 1, 4'd0,  0, S_IDLE,   C_ZERO,   16'hFFFF, "wrap_idle");
    cyc(1, 1, 1, 4'd12, 0, S_FETCH,  C_FACK,   16'hFFFF, "wrap_fetch");
    cyc(1, 1, 1, 4'd12, 0, S_DECODE, C_DECILL, 16'hFFFF, "wrap_decode");

    // Branch to make the count nonzero, then reset during MEM_RD
    cyc(1, 1, 1, 4'd1, 0, S_FETCH,  C_FACK, 16'd0, "pre_fetch");
    cyc(1, 1, 1, 4'd1, 0, S_DECODE, C_DEC,  16'd0, "pre_decode");
    cyc(1, 1, 1, 4'd1, 0, S_BRANCH, C_BR,   16'd0, "pre_branch");
    cyc(1, 1, 1, 4'd3, 0, S_FETCH,  C_FACK, 16'd1, "rst_fetch");
    cyc(1, 0, 1, 4'd3, 0, S_DECODE, C_DEC,  16'd1, "rst_decode");
    cyc(1, 0, 1, 4'd3, 0, S_ADDR,   C_ADDR, 16'd1, "rst_addr");
    cyc(1, 0, 0, 4'd3, 0, S_MEM_RD, C_MRD,  16'd1, "rst_mem_wait");
    cyc(0, 0, 0, 4'd3, 0, S_MEM_RD, C_MRD,  16'd1, "rst_assert");
    cyc(1, 0, 1, 4'd3, 0, S_IDLE,   C_ZERO, 16'd0, "rst_idle");
    cyc(1, 0, 1, 4'd3, 0, S_IDLE,   C_ZERO, 16'd0, "late_ack_ignored");

    // Let the monitor drain the last entry
    @(posedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
